// File: rtl/mac_share_pkg.sv
// Shared types and helpers for the MAC-sharing arbiter.
// Also used by the saturating MAC core.
package mac_share_pkg;
  localparam int W_DEF       = 16;
  localparam int MAX_LEN_DEF = 64;

  typedef enum logic [1:0] {IDLE, BURST, DRAIN, RESULT} state_t;

  // Clamp a wide signed value to the signed range of a w-bit word.
  // The caller takes the low w bits of the result.
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction
endpackage

// File: rtl/sat_mac_core.sv
// Saturating MAC datapath: registered product stage feeding a clamped accumulator.
// Optional ReLU on the output.
module sat_mac_core
  import mac_share_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter bit RELU = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_clear,
  input  logic                i_beat_en,
  input  logic signed [W-1:0] i_x,
  input  logic signed [W-1:0] i_f,
  output logic signed [W-1:0] o_y
);
  logic signed [2*W-1:0] w_prod_full;
  logic signed [W-1:0]   w_prod_q, w_sum_q;
  logic signed [W-1:0]   r_prod, r_acc;
  logic                  r_prod_valid;

  assign w_prod_full = (2*W)'(i_x) * (2*W)'(i_f);
  assign w_prod_q    = W'(sat_w(64'(w_prod_full), W));
  assign w_sum_q     = W'(sat_w(64'(r_acc) + 64'(r_prod), W));

  // The accumulator only advances when the product stage holds a fresh beat.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_prod       <= '0;
      r_acc        <= '0;
      r_prod_valid <= 1'b0;
    end else if (i_clear) begin
      r_prod       <= '0;
      r_acc        <= '0;
      r_prod_valid <= 1'b0;
    end else begin
      r_prod_valid <= i_beat_en;
      if (i_beat_en)    r_prod <= w_prod_q;
      if (r_prod_valid) r_acc  <= w_sum_q;
    end
  end

  assign o_y = (RELU && r_acc[W-1]) ? '0 : r_acc;
endmodule

// File: rtl/mac_share_arbiter.sv
// Round-robin arbiter that locks the shared saturating MAC to one conv engine
// for a whole dot-product burst and returns the result tagged by owner id.
module mac_share_arbiter
  import mac_share_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int W       = W_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter bit RELU    = 1'b1,
  localparam int IW     = $clog2(N_REQ),
  localparam int CW     = $clog2(MAX_LEN + 1)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [N_REQ-1:0]   i_op_valid,
  input  logic [N_REQ*W-1:0] i_op_x,
  input  logic [N_REQ*W-1:0] i_op_f,
  input  logic [N_REQ-1:0]   i_op_last,
  output logic [N_REQ-1:0]   o_op_ready,
  output logic [N_REQ-1:0]   o_gnt,
  output logic [W-1:0]       o_y_data,
  output logic [IW-1:0]      o_y_id,
  output logic [CW-1:0]      o_y_len,
  output logic               o_y_trunc,
  output logic               o_y_valid,
  input  logic               i_y_ready
);
  state_t              r_state, w_next;
  logic [IW-1:0]       r_owner, r_rr_ptr, w_win;
  logic [CW-1:0]       r_count;
  logic                r_trunc;
  logic [N_REQ-1:0]    w_onehot;
  logic signed [W-1:0] w_x, w_f, w_y;
  logic                w_beat, w_last_beat, w_at_max;

  assign w_onehot    = N_REQ'(1) << r_owner;
  assign w_x         = i_op_x[r_owner*W +: W];
  assign w_f         = i_op_f[r_owner*W +: W];
  assign w_beat      = (r_state == BURST) && i_op_valid[r_owner];
  assign w_at_max    = (r_count == CW'(MAX_LEN - 1));
  assign w_last_beat = w_beat && (i_op_last[r_owner] || w_at_max);

  // Scan from the slot after rr_ptr; the last hit in this descending loop is the nearest.
  always_comb begin
    w_win = r_rr_ptr;
    for (int k = N_REQ; k >= 1; k--) begin
      if (i_req[(int'(r_rr_ptr) + k) % N_REQ]) w_win = IW'((int'(r_rr_ptr) + k) % N_REQ);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_owner  <= '0;
      r_rr_ptr <= IW'(N_REQ - 1);
      r_count  <= '0;
      r_trunc  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && |i_req) begin
        r_owner  <= w_win;
        r_rr_ptr <= w_win;
        r_count  <= '0;
        r_trunc  <= 1'b0;
      end
      if (w_beat)      r_count <= r_count + CW'(1);
      if (w_last_beat) r_trunc <= !i_op_last[r_owner];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (|i_req) w_next = BURST;
      BURST:   if (w_last_beat) w_next = DRAIN;
      DRAIN:   w_next = RESULT;
      RESULT:  if (i_y_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    o_gnt      = '0;
    o_op_ready = '0;
    o_y_valid  = 1'b0;
    o_y_data   = '0;
    o_y_id     = '0;
    o_y_len    = '0;
    o_y_trunc  = 1'b0;
    case (r_state)
      BURST: begin
        o_gnt      = w_onehot;
        o_op_ready = w_onehot;
      end
      DRAIN:  o_gnt = w_onehot;
      RESULT: begin
        o_y_valid = 1'b1;
        o_y_data  = w_y;
        o_y_id    = r_owner;
        o_y_len   = r_count;
        o_y_trunc = r_trunc;
      end
      default: ;
    endcase
  end

  sat_mac_core #(.W(W), .RELU(RELU)) u_core (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (r_state == IDLE),
    .i_beat_en (w_beat),
    .i_x       (w_x),
    .i_f       (w_f),
    .o_y       (w_y)
  );
endmodule

// File: tb/tb_mac_share_arbiter.sv
// Directed bench for mac_share_arbiter: table-driven bursts plus hand sequences
// for round robin, truncation, result back-pressure and mid-burst reset.
module tb_mac_share_arbiter;
  localparam int N = 4, W = 16, ML = 64;

  logic           clk = 1'b0, reset = 1'b1;
  logic [N-1:0]   req = '0, op_valid = '0, op_last = '0;
  logic [N*W-1:0] op_x = '0, op_f = '0;
  logic           y_ready = 1'b0;
  logic [N-1:0]   gnt, op_ready, gnt2, op_ready2;
  logic [W-1:0]   y_data, y_data2;
  logic [1:0]     y_id, y_id2;
  logic [6:0]     y_len, y_len2;
  logic           y_trunc, y_trunc2, y_valid, y_valid2;
  int             total = 0, bad = 0;

  always #5 clk = ~clk;

  mac_share_arbiter #(.N_REQ(N), .W(W), .MAX_LEN(ML), .RELU(1'b1)) dut (
    .i_clk(clk), .i_reset(reset), .i_req(req), .i_op_valid(op_valid), .i_op_x(op_x),
    .i_op_f(op_f), .i_op_last(op_last), .o_op_ready(op_ready), .o_gnt(gnt),
    .o_y_data(y_data), .o_y_id(y_id), .o_y_len(y_len), .o_y_trunc(y_trunc),
    .o_y_valid(y_valid), .i_y_ready(y_ready));

  mac_share_arbiter #(.N_REQ(N), .W(W), .MAX_LEN(ML), .RELU(1'b0)) dut_raw (
    .i_clk(clk), .i_reset(reset), .i_req(req), .i_op_valid(op_valid), .i_op_x(op_x),
    .i_op_f(op_f), .i_op_last(op_last), .o_op_ready(op_ready2), .o_gnt(gnt2),
    .o_y_data(y_data2), .o_y_id(y_id2), .o_y_len(y_len2), .o_y_trunc(y_trunc2),
    .o_y_valid(y_valid2), .i_y_ready(y_ready));

  typedef struct {
    logic [3:0]       req;
    int               id;
    int               nb;
    logic             gap;
    logic [2:0][15:0] xs;
    logic [2:0][15:0] fs;
    logic [15:0]      y;
    logic [15:0]      yraw;
    int               len;
  } vec_t;

  vec_t vecs[5];

  function automatic vec_t mk(input logic [3:0] r, input int id, input int nb, input logic gap,
                              input logic [15:0] x0, input logic [15:0] f0,
                              input logic [15:0] x1, input logic [15:0] f1,
                              input logic [15:0] x2, input logic [15:0] f2,
                              input logic [15:0] y, input logic [15:0] yraw, input int len);
    vec_t v;
    v.req = r; v.id = id; v.nb = nb; v.gap = gap;
    v.xs = {x2, x1, x0}; v.fs = {f2, f1, f0};
    v.y = y; v.yraw = yraw; v.len = len;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int id, input logic [15:0] x, input logic [15:0] f, input logic last);
    op_valid = '0; op_last = '0; op_x = '0; op_f = '0;
    op_valid[id] = 1'b1;
    op_last[id]  = last;
    op_x[id*W +: W] = x;
    op_f[id*W +: W] = f;
  endtask

  task automatic clr_beat();
    op_valid = '0; op_last = '0; op_x = '0; op_f = '0;
  endtask

  task automatic accept();
    y_ready = 1'b1;
    tick();
    y_ready = 1'b0;
    chk("idle_vld", 16'(y_valid), 16'h0);
    chk("idle_gnt", 16'(gnt), 16'h0);
  endtask

  task automatic do_burst(input vec_t v);
    req = v.req;
    tick();
    req = '0;
    chk("gnt", 16'(gnt), 16'(1 << v.id));
    for (int b = 0; b < v.nb; b++) begin
      set_beat(v.id, v.xs[b], v.fs[b], b == v.nb - 1);
      chk("op_ready", 16'(op_ready), 16'(1 << v.id));
      tick();
      if (v.gap && b == 0) begin
        clr_beat();
        tick();
      end
    end
    clr_beat();
    chk("drain_vld", 16'(y_valid), 16'h0);
    tick();
    chk("y_valid", 16'(y_valid), 16'h1);
    chk("y_data", y_data, v.y);
    chk("y_raw", y_data2, v.yraw);
    chk("y_id", 16'(y_id), 16'(v.id));
    chk("y_len", 16'(y_len), 16'(v.len));
    chk("y_trunc", 16'(y_trunc), 16'h0);
    accept();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    vecs[0] = mk(4'b0001, 0, 3, 1'b1, 16'sd2, 16'sd5, 16'sd3, -16'sd1, 16'sd4, 16'sd10,
                 16'sd47, 16'sd47, 3);
    vecs[1] = mk(4'b0010, 1, 2, 1'b0, 16'sd32767, 16'sd2, 16'sd32767, 16'sd1, 16'sd0, 16'sd0,
                 16'sd32767, 16'sd32767, 2);
    vecs[2] = mk(4'b0100, 2, 1, 1'b0, -16'sd5, 16'sd7, 16'sd0, 16'sd0, 16'sd0, 16'sd0,
                 16'sd0, -16'sd35, 1);
    vecs[3] = mk(4'b1001, 3, 3, 1'b0, -16'sd100, -16'sd100, 16'sh8000, 16'sh8000, 16'sh8000, 16'sd1,
                 16'sd0, -16'sd1, 3);
    vecs[4] = mk(4'b1001, 0, 2, 1'b0, 16'sh8000, 16'sd2, -16'sd1, 16'sd1, 16'sd0, 16'sd0,
                 16'sd0, 16'sh8000, 2);

    tick();
    chk("rst_gnt", 16'(gnt), 16'h0);
    chk("rst_rdy", 16'(op_ready), 16'h0);
    chk("rst_vld", 16'(y_valid), 16'h0);
    chk("rst_data", y_data, 16'h0);
    chk("rst_id", 16'(y_id), 16'h0);
    chk("rst_len", 16'(y_len), 16'h0);
    chk("rst_trunc", 16'(y_trunc), 16'h0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) do_burst(vecs[i]);

    // all requesters held: grants rotate 0,1,2,3,0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("rr_gnt", 16'(gnt), 16'(1 << (n % 4)));
      set_beat(n % 4, 16'd1, 16'((n % 4) + 1), 1'b1);
      tick();
      clr_beat();
      tick();
      chk("rr_vld", 16'(y_valid), 16'h1);
      chk("rr_id", 16'(y_id), 16'(n % 4));
      chk("rr_data", y_data, 16'((n % 4) + 1));
      accept();
    end
    req = '0;

    // no op_last: burst closes after MAX_LEN beats
    req = 4'b0100;
    tick();
    req = '0;
    chk("tr_gnt", 16'(gnt), 16'h4);
    for (int b = 0; b < ML; b++) begin
      set_beat(2, 16'd1, 16'd1, 1'b0);
      if (b == ML - 1) chk("tr_rdy", 16'(op_ready), 16'h4);
      tick();
    end
    clr_beat();
    chk("tr_drain_rdy", 16'(op_ready), 16'h0);
    chk("tr_drain_gnt", 16'(gnt), 16'h4);
    tick();
    chk("tr_vld", 16'(y_valid), 16'h1);
    chk("tr_data", y_data, 16'd64);
    chk("tr_len", 16'(y_len), 16'd64);
    chk("tr_trunc", 16'(y_trunc), 16'h1);
    chk("tr_id", 16'(y_id), 16'd2);
    accept();

    // result held under back-pressure
    req = 4'b0001;
    tick();
    req = '0;
    set_beat(0, 16'd3, 16'd4, 1'b1);
    tick();
    clr_beat();
    tick();
    for (int c = 0; c < 10; c++) begin
      chk("bp_vld", 16'(y_valid), 16'h1);
      chk("bp_data", y_data, 16'd12);
      chk("bp_rdy", 16'(op_ready), 16'h0);
      tick();
    end
    accept();

    // reset mid-burst aborts; requester 0 wins next
    req = 4'b0100;
    tick();
    req = '0;
    chk("ab_gnt", 16'(gnt), 16'h4);
    set_beat(2, 16'd1, 16'd1, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("ab_rst_gnt", 16'(gnt), 16'h0);
    chk("ab_rst_rdy", 16'(op_ready), 16'h0);
    tick();
    reset = 1'b0;
    clr_beat();
    for (int c = 0; c < 4; c++) begin
      chk("ab_no_vld", 16'(y_valid), 16'h0);
      tick();
    end
    req = 4'b0101;
    tick();
    req = '0;
    chk("ab_regnt", 16'(gnt), 16'h1);
    set_beat(0, 16'd1, 16'd9, 1'b1);
    tick();
    clr_beat();
    tick();
    chk("ab_vld", 16'(y_valid), 16'h1);
    chk("ab_data", y_data, 16'd9);
    chk("ab_len", 16'(y_len), 16'd1);
    accept();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
